// File: rtl/noc_port_arbiter.sv
// Round-robin arbiter and output mux for one NoC switch output port, with bounded bursts.
// Define NOC_ARB_STATS_EN to add saturating beat, stall and per-requester grant counters.
module noc_port_arbiter #(
   parameter int NUM_REQ   = 3,
   parameter int DataWidth = 36,
   parameter int AddrWidth = 4,
   parameter int DestMin   = 0,
   parameter int DestMax   = 0,
   parameter int MaxBurst  = 8
) (
   input  logic                         i_clk,
   input  logic                         i_reset_n,
   input  logic [NUM_REQ*DataWidth-1:0] i_req_data,
   input  logic [NUM_REQ-1:0]           i_req_valid,
   output logic [NUM_REQ-1:0]           o_req_ready,
   output logic [DataWidth-1:0]         o_data,
   output logic                         o_data_valid,
   input  logic                         i_data_ready,
   output logic [NUM_REQ-1:0]           o_grant,
   output logic                         o_busy
`ifdef NOC_ARB_STATS_EN
   ,
   output logic [31:0]                  o_beat_count,
   output logic [31:0]                  o_stall_count,
   output logic [NUM_REQ*16-1:0]        o_grant_count
`endif
);

   localparam int IdxW = $clog2(NUM_REQ);
   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_GRANT = 1'b1;
   localparam logic [7:0] BurstLast = 8'(MaxBurst - 1);

   logic [0:0]           r_state;
   logic [NUM_REQ-1:0]   r_grant;
   logic [IdxW-1:0]      r_rr_ptr;
   logic [7:0]           r_beat_cnt;

   logic [NUM_REQ-1:0]   w_elig;
   logic                 w_any;
   logic [IdxW-1:0]      w_pick;
   logic                 w_busy;
   logic                 w_elig_g;
   logic                 w_xfer;
   logic                 w_release;
   logic                 w_new_grant;
   logic [DataWidth-1:0] w_head_g;

   // Range checks collapse to constants when a bound sits at the edge of the address space.
   for (genvar k = 0; k < NUM_REQ; k++) begin : g_elig
      logic [AddrWidth-1:0] w_addr;
      logic                 w_lo_ok;
      logic                 w_hi_ok;
      assign w_addr = i_req_data[k*DataWidth + DataWidth - 1 -: AddrWidth];
      if (DestMin > 0) begin : g_lo
         assign w_lo_ok = (w_addr >= AddrWidth'(DestMin));
      end else begin : g_lo_any
         assign w_lo_ok = 1'b1;
      end
      if (DestMax < (2**AddrWidth) - 1) begin : g_hi
         assign w_hi_ok = (w_addr <= AddrWidth'(DestMax));
      end else begin : g_hi_any
         assign w_hi_ok = 1'b1;
      end
      assign w_elig[k] = i_req_valid[k] & w_lo_ok & w_hi_ok;
   end

   // While granted, r_rr_ptr holds the granted index, so one search serves IDLE and release.
   always_comb begin
      int v_idx;
      // NOTE: defaults first so no path through the loop can infer a latch.
      v_idx  = 0;
      w_any  = 1'b0;
      w_pick = r_rr_ptr;
      for (int i = 1; i <= NUM_REQ; i++) begin
         v_idx = int'(r_rr_ptr) + i;
         if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
         if (!w_any && w_elig[IdxW'(v_idx)]) begin
            w_any  = 1'b1;
            w_pick = IdxW'(v_idx);
         end
      end
   end

   assign w_busy      = (r_state == S_GRANT);
   assign w_head_g    = i_req_data[r_rr_ptr*DataWidth +: DataWidth];
   assign w_elig_g    = w_busy & w_elig[r_rr_ptr];
   assign w_xfer      = w_elig_g & i_data_ready;
   assign w_release   = w_busy & (~w_elig_g | (w_xfer & (r_beat_cnt == BurstLast)));
   assign w_new_grant = (~w_busy | w_release) & w_any;

   assign o_data       = w_busy ? w_head_g : '0;
   assign o_data_valid = w_elig_g;
   assign o_req_ready  = r_grant & {NUM_REQ{w_xfer}};
   assign o_grant      = r_grant;
   assign o_busy       = w_busy;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (!i_reset_n) begin
         r_state    <= S_IDLE;
         r_grant    <= '0;
         r_rr_ptr   <= IdxW'(NUM_REQ - 1);
         r_beat_cnt <= '0;
      end else if (w_new_grant) begin
         r_state    <= S_GRANT;
         r_grant    <= NUM_REQ'(1) << w_pick;
         r_rr_ptr   <= w_pick;
         r_beat_cnt <= '0;
      end else if (w_release) begin
         r_state    <= S_IDLE;
         r_grant    <= '0;
         r_beat_cnt <= '0;
      end else if (w_xfer) begin
         r_beat_cnt <= r_beat_cnt + 8'd1;
      end
   end

`ifdef NOC_ARB_STATS_EN
   logic [31:0] r_beat_count;
   logic [31:0] r_stall_count;
   logic [15:0] r_grant_count [NUM_REQ];

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_beat_count  <= '0;
         r_stall_count <= '0;
         for (int k = 0; k < NUM_REQ; k++) r_grant_count[k] <= '0;
      end else begin
         if (w_xfer && (r_beat_count != '1)) r_beat_count <= r_beat_count + 32'd1;
         if (w_elig_g && !i_data_ready && (r_stall_count != '1))
            r_stall_count <= r_stall_count + 32'd1;
         for (int k = 0; k < NUM_REQ; k++) begin
            if (w_new_grant && (w_pick == IdxW'(k)) && (r_grant_count[k] != '1))
               r_grant_count[k] <= r_grant_count[k] + 16'd1;
         end
      end
   end

   assign o_beat_count  = r_beat_count;
   assign o_stall_count = r_stall_count;
   for (genvar k = 0; k < NUM_REQ; k++) begin : g_gcnt
      assign o_grant_count[k*16 +: 16] = r_grant_count[k];
   end
`endif

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Directed bench for noc_port_arbiter: three requesters, destinations 2..5, bursts of two.
// Each requester is a FIFO model whose head is popped whenever its ready bit is seen high.
module tb_noc_port_arbiter;

   localparam int NR = 3;
   localparam int DW = 36;

   logic             i_clk;
   logic             i_reset_n;
   logic [NR*DW-1:0] i_req_data;
   logic [NR-1:0]    i_req_valid;
   logic [NR-1:0]    o_req_ready;
   logic [DW-1:0]    o_data;
   logic             o_data_valid;
   logic             i_data_ready;
   logic [NR-1:0]    o_grant;
   logic             o_busy;
`ifdef NOC_ARB_STATS_EN
   logic [31:0]      o_beat_count;
   logic [31:0]      o_stall_count;
   logic [NR*16-1:0] o_grant_count;
`endif

   noc_port_arbiter #(
      .NUM_REQ(NR), .DataWidth(DW), .AddrWidth(4),
      .DestMin(2), .DestMax(5), .MaxBurst(2)
   ) dut (
      .i_clk(i_clk),
      .i_reset_n(i_reset_n),
      .i_req_data(i_req_data),
      .i_req_valid(i_req_valid),
      .o_req_ready(o_req_ready),
      .o_data(o_data),
      .o_data_valid(o_data_valid),
      .i_data_ready(i_data_ready),
      .o_grant(o_grant),
      .o_busy(o_busy)
`ifdef NOC_ARB_STATS_EN
      ,
      .o_beat_count(o_beat_count),
      .o_stall_count(o_stall_count),
      .o_grant_count(o_grant_count)
`endif
   );

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];
   logic [DW-1:0] q2[$];

   logic          ob_valid;
   logic [DW-1:0] ob_data;
   logic [NR-1:0] ob_grant;
   logic [NR-1:0] ob_ready;
   logic          ob_busy;

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [DW-1:0] mkflit(int k, int n, logic [3:0] addr);
      return {addr, 32'(k*256 + n)};
   endfunction

   task automatic apply_inputs();
      i_req_valid = '0;
      i_req_data  = '0;
      if (q0.size() > 0) begin i_req_valid[0] = 1'b1; i_req_data[0*DW +: DW] = q0[0]; end
      if (q1.size() > 0) begin i_req_valid[1] = 1'b1; i_req_data[1*DW +: DW] = q1[0]; end
      if (q2.size() > 0) begin i_req_valid[2] = 1'b1; i_req_data[2*DW +: DW] = q2[0]; end
   endtask

   // Called at posedge+1: drive heads, sample mid-cycle, pop what the coming edge pops.
   task automatic tick();
      apply_inputs();
      #4;
      ob_valid = o_data_valid;
      ob_data  = o_data;
      ob_grant = o_grant;
      ob_ready = o_req_ready;
      ob_busy  = o_busy;
      if (ob_ready[0] && q0.size() > 0) void'(q0.pop_front());
      if (ob_ready[1] && q1.size() > 0) void'(q1.pop_front());
      if (ob_ready[2] && q2.size() > 0) void'(q2.pop_front());
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_reset_n    = 1'b0;
      i_data_ready = 1'b0;
      q0.delete(); q1.delete(); q2.delete();
      apply_inputs();
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_reset_n = 1'b1;
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      i_reset_n    = 1'b0;
      i_data_ready = 1'b1;
      q0.delete(); q1.delete(); q2.delete();
      q0.push_back(mkflit(0, 0, 4'd2));
      apply_inputs();
      repeat (2) @(posedge i_clk);
      #1;
      total_cnt++; if (o_grant !== 3'b000) $display("FAIL reset_grant: got=%b exp=000", o_grant); else pass_cnt++;
      total_cnt++; if (o_data_valid !== 1'b0) $display("FAIL reset_valid: got=%b exp=0", o_data_valid); else pass_cnt++;
      total_cnt++; if (o_req_ready !== 3'b000) $display("FAIL reset_ready: got=%b exp=000", o_req_ready); else pass_cnt++;
      total_cnt++; if (o_data !== '0) $display("FAIL reset_data: got=%h exp=0", o_data); else pass_cnt++;
      total_cnt++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got=%b exp=0", o_busy); else pass_cnt++;
   endtask

   task automatic test_single();
      do_reset();
      for (int i = 0; i < 5; i++) q0.push_back(mkflit(0, i, 4'd2));
      i_data_ready = 1'b1;
      tick();
      total_cnt++; if (ob_valid !== 1'b0) $display("FAIL single_lat: valid=%b exp=0", ob_valid); else pass_cnt++;
      for (int i = 0; i < 5; i++) begin
         tick();
         total_cnt++;
         if ({ob_valid, ob_grant, ob_ready, ob_data} !== {1'b1, 3'b001, 3'b001, mkflit(0, i, 4'd2)})
            $display("FAIL single_beat%0d: v=%b g=%b r=%b d=%h exp v=1 g=001 r=001 d=%h",
                     i, ob_valid, ob_grant, ob_ready, ob_data, mkflit(0, i, 4'd2));
         else pass_cnt++;
      end
      tick();
      total_cnt++;
      if ({ob_valid, ob_grant, ob_ready, ob_busy} !== {1'b0, 3'b001, 3'b000, 1'b1})
         $display("FAIL single_drop: v=%b g=%b r=%b b=%b exp v=0 g=001 r=000 b=1", ob_valid, ob_grant, ob_ready, ob_busy);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({ob_grant, ob_busy} !== {3'b000, 1'b0})
         $display("FAIL single_idle: g=%b b=%b exp g=000 b=0", ob_grant, ob_busy);
      else pass_cnt++;
   endtask

   task automatic test_round_robin();
      int seq [7] = '{0, 0, 1, 1, 2, 2, 0};
      logic [3:0] addr [3] = '{4'd2, 4'd3, 4'd5};
      int nxt [3] = '{0, 0, 0};
      logic [DW-1:0] exp_d;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         q0.push_back(mkflit(0, i, addr[0]));
         q1.push_back(mkflit(1, i, addr[1]));
         q2.push_back(mkflit(2, i, addr[2]));
      end
      i_data_ready = 1'b1;
      tick();
      for (int i = 0; i < 7; i++) begin
         tick();
         exp_d = mkflit(seq[i], nxt[seq[i]], addr[seq[i]]);
         nxt[seq[i]]++;
         total_cnt++;
         if ({ob_valid, ob_grant, ob_ready, ob_data} !== {1'b1, 3'(1 << seq[i]), 3'(1 << seq[i]), exp_d})
            $display("FAIL rr_beat%0d: v=%b g=%b r=%b d=%h exp v=1 g=%b d=%h",
                     i, ob_valid, ob_grant, ob_ready, ob_data, 3'(1 << seq[i]), exp_d);
         else pass_cnt++;
      end
   endtask

   task automatic test_out_of_range();
      int pops0;
      do_reset();
      for (int i = 0; i < 3; i++) q0.push_back(mkflit(0, i, 4'd2));
      for (int i = 0; i < 2; i++) q1.push_back(mkflit(1, i, 4'd6));
      for (int i = 0; i < 2; i++) q2.push_back(mkflit(2, i, 4'd1));
      i_data_ready = 1'b1;
      pops0 = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (ob_ready[0]) pops0++;
         total_cnt++;
         if ((ob_ready[2:1] | ob_grant[2:1]) !== 2'b00)
            $display("FAIL oor_cycle%0d: g=%b r=%b exp bits[2:1]=00", c, ob_grant, ob_ready);
         else pass_cnt++;
      end
      total_cnt++; if (pops0 !== 3) $display("FAIL oor_pops0: got=%0d exp=3", pops0); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int i = 0; i < 3; i++) q2.push_back(mkflit(2, i, 4'd4));
      i_data_ready = 1'b0;
      tick();
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == 1) begin
            q0.push_back(mkflit(0, 0, 4'd2));
            q0.push_back(mkflit(0, 1, 4'd2));
         end
         total_cnt++;
         if ({ob_valid, ob_grant, ob_ready, ob_data} !== {1'b1, 3'b100, 3'b000, mkflit(2, 0, 4'd4)})
            $display("FAIL bp_hold%0d: v=%b g=%b r=%b d=%h exp v=1 g=100 r=000 d=%h",
                     c, ob_valid, ob_grant, ob_ready, ob_data, mkflit(2, 0, 4'd4));
         else pass_cnt++;
      end
      i_data_ready = 1'b1;
      tick();
      total_cnt++;
      if ({ob_grant, ob_ready, ob_data} !== {3'b100, 3'b100, mkflit(2, 0, 4'd4)})
         $display("FAIL bp_go0: g=%b r=%b d=%h exp g=100 r=100", ob_grant, ob_ready, ob_data);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({ob_grant, ob_ready, ob_data} !== {3'b100, 3'b100, mkflit(2, 1, 4'd4)})
         $display("FAIL bp_go1: g=%b r=%b d=%h exp g=100 r=100", ob_grant, ob_ready, ob_data);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({ob_valid, ob_grant, ob_ready, ob_data} !== {1'b1, 3'b001, 3'b001, mkflit(0, 0, 4'd2)})
         $display("FAIL bp_rotate: v=%b g=%b r=%b d=%h exp v=1 g=001 r=001", ob_valid, ob_grant, ob_ready, ob_data);
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         q0.push_back(mkflit(0, i, 4'd2));
         q1.push_back(mkflit(1, i, 4'd3));
         q2.push_back(mkflit(2, i, 4'd5));
      end
      i_data_ready = 1'b1;
      repeat (4) tick();
      apply_inputs();
      #2;
      i_reset_n = 1'b0;
      #1;
      total_cnt++;
      if ({o_grant, o_data_valid, o_req_ready} !== {3'b000, 1'b0, 3'b000})
         $display("FAIL areset_now: g=%b v=%b r=%b exp g=000 v=0 r=000", o_grant, o_data_valid, o_req_ready);
      else pass_cnt++;
      @(negedge i_clk);
      @(negedge i_clk);
      i_reset_n = 1'b1;
      @(posedge i_clk);
      #1;
      tick();
      total_cnt++;
      if ({ob_grant, ob_data} !== {3'b001, mkflit(0, 2, 4'd2)})
         $display("FAIL areset_first: g=%b d=%h exp g=001 d=%h", ob_grant, ob_data, mkflit(0, 2, 4'd2));
      else pass_cnt++;
      tick();
      tick();
      total_cnt++;
      if ({ob_grant, ob_data} !== {3'b010, mkflit(1, 1, 4'd3)})
         $display("FAIL areset_next: g=%b d=%h exp g=010 d=%h", ob_grant, ob_data, mkflit(1, 1, 4'd3));
      else pass_cnt++;
   endtask

`ifdef NOC_ARB_STATS_EN
   task automatic test_stats();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         q0.push_back(mkflit(0, i, 4'd2));
         q1.push_back(mkflit(1, i, 4'd3));
      end
      i_data_ready = 1'b1;
      tick();
      for (int c = 1; c <= 27; c++) begin
         i_data_ready = !((c <= 13) && (c % 2 == 1));
         tick();
      end
      i_data_ready = 1'b1;
      repeat (3) tick();
      total_cnt++; if (o_beat_count !== 32'd20) $display("FAIL stats_beats: got=%0d exp=20", o_beat_count); else pass_cnt++;
      total_cnt++; if (o_stall_count !== 32'd7) $display("FAIL stats_stalls: got=%0d exp=7", o_stall_count); else pass_cnt++;
      total_cnt++;
      if (o_grant_count !== {16'd0, 16'd6, 16'd5})
         $display("FAIL stats_grants: got=%h exp=%h", o_grant_count, {16'd0, 16'd6, 16'd5});
      else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_out_of_range();
      test_backpressure();
      test_async_reset();
`ifdef NOC_ARB_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
